// File: rtl/cpu_irq_pkg.sv
// Shared constants and helpers for the CPU interrupt generator.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: channel ceiling, index type, IM0/IM1 default vector, IM2 vector offset.
package cpu_irq_pkg;

  localparam int IRQ_MAX_CH = 8;

  // Wide enough to index any of IRQ_MAX_CH sources.
  typedef logic [$clog2(IRQ_MAX_CH)-1:0] irq_idx_t;

  // RST 38h opcode: what the bus floats to for IM0/IM1 games.
  localparam logic [7:0] VEC_DEFAULT = 8'hFF;

  // IM2 tables hold 16-bit pointers, so consecutive sources are 2 bytes apart.
  function automatic logic [7:0] vec_offset(input irq_idx_t k);
    return {{(8 - $bits(irq_idx_t) - 1){1'b0}}, k, 1'b0};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit priority encoder; index 0 has the highest priority.
// Latency: combinational.
// Backpressure: none.
//
// Ports: req (N request bits) -> idx (lowest set index), vld (any bit set).
module irq_prio_enc
  import cpu_irq_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  output irq_idx_t     idx,
  output logic         vld
);

  // Scan from the top down so the lowest set bit is the last to write idx.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = irq_idx_t'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_irq_gen.sv
// Z80 interrupt generator: stretched NMI, prioritised ack-cleared INT, CPU clock enable.
// Latency: 1 clk_sys from a sampled source rise to nmi_n/int_n low; ack acts 1 clk after sampling.
// Backpressure: none; pending INTs persist until acknowledged or disabled, NMI retriggers reload.
//
// Ports: clk_sys, reset_n (async, active low); src/irq_en (NCH sources and enables);
//        cpu_m1/cpu_io (acknowledge = both high); cen, nmi_n, int_n, vec, pend (debug).
// Build option: define CPU_IRQ_VEC_EN for an IM2 vector on vec; otherwise vec is 8'hFF.
module cpu_irq_gen
  import cpu_irq_pkg::*;
#(
  parameter int         NCH      = 2,
  parameter int         NMI_CH   = 0,
  parameter int         NMI_HOLD = 255,
  parameter int         CEN_DIV  = 17,
  parameter logic [7:0] VEC_BASE = 8'hE0
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  input  logic [NCH-1:0] src,
  input  logic [NCH-1:0] irq_en,
  input  logic           cpu_m1,
  input  logic           cpu_io,
  output logic           cen,
  output logic           nmi_n,
  output logic           int_n,
  output logic [7:0]     vec,
  output logic [NCH-1:0] pend
);

  localparam int NW = $clog2(NMI_HOLD + 1);
  // A divide-by-1 still needs a 1-bit counter that simply sits at zero.
  localparam int CW = (CEN_DIV > 1) ? $clog2(CEN_DIV) : 1;
  localparam logic [NW-1:0]  NMI_LOAD = NW'(NMI_HOLD);
  localparam logic [CW-1:0]  CEN_LAST = CW'(CEN_DIV - 1);
  // The NMI source never contributes to the INT pending set.
  localparam logic [NCH-1:0] INT_MASK = ~(NCH'(1) << NMI_CH);

  logic [NCH-1:0] src_q;
  logic           ack_q;
  logic [NCH-1:0] rise;
  logic           ack;
  logic           ack_first;
  logic [NW-1:0]  nmi_cnt;
  logic [CW-1:0]  cen_cnt;
  logic [NCH-1:0] pend_nxt;
  logic [NCH-1:0] clr_mask;
  irq_idx_t       enc_idx;
  logic           enc_vld;

  assign rise      = src & ~src_q & irq_en;
  assign ack       = cpu_m1 & cpu_io;
  // An acknowledge cycle spans several clk_sys cycles; only its first one counts.
  assign ack_first = ack & ~ack_q;

  irq_prio_enc #(.N(NCH)) u_enc (
    .req (pend),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  assign clr_mask = (ack_first && enc_vld) ? (NCH'(1) << enc_idx) : '0;

  // Set after clear: a rise landing on the acknowledged bit keeps it pending.
  // Dropping an enable discards whatever was pending on that source.
  always_comb begin
    pend_nxt = ((pend & ~clr_mask) | rise) & irq_en & INT_MASK;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      src_q   <= '0;
      ack_q   <= 1'b0;
      pend    <= '0;
      nmi_cnt <= '0;
      cen_cnt <= '0;
    end else begin
      src_q <= src;
      ack_q <= ack;
      pend  <= pend_nxt;
      // Retrigger reloads the full hold time even mid-pulse.
      if (rise[NMI_CH]) begin
        nmi_cnt <= NMI_LOAD;
      end else if (nmi_cnt != '0) begin
        nmi_cnt <= nmi_cnt - NW'(1);
      end
      if (cen_cnt == CEN_LAST) begin
        cen_cnt <= '0;
      end else begin
        cen_cnt <= cen_cnt + CW'(1);
      end
    end
  end

  assign nmi_n = (nmi_cnt == '0);
  assign int_n = ~|pend;
  assign cen   = (cen_cnt == CEN_LAST);

`ifdef CPU_IRQ_VEC_EN
  logic [7:0] vec_q;

  // Vector holds across acks that find nothing pending.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vec_q <= VEC_BASE;
    end else if (ack_first && enc_vld) begin
      vec_q <= VEC_BASE + vec_offset(enc_idx);
    end
  end

  assign vec = vec_q;
`else
  assign vec = VEC_DEFAULT;
`endif

endmodule

// File: tb/tb_cpu_irq_gen.sv
// Bench for cpu_irq_gen: table vectors and hand sequences plus randomized traffic vs a reference model.
module tb_cpu_irq_gen;

  localparam int         HOLD  = 4;
  localparam int         DIV_A = 17;
  localparam logic [7:0] VBASE = 8'hE0;
`ifdef CPU_IRQ_VEC_EN
  localparam bit VEC_ON = 1'b1;
`else
  localparam bit VEC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance A: 4 sources, divide-by-17 clock enable.
  logic [3:0] a_src, a_en, a_pend;
  logic       a_m1, a_io, a_cen, a_nmi_n, a_int_n;
  logic [7:0] a_vec;
  // Instance B: 2 sources, divide-by-1 clock enable.
  logic [1:0] b_src, b_en, b_pend;
  logic       b_m1, b_io, b_cen, b_nmi_n, b_int_n;
  logic [7:0] b_vec;

  cpu_irq_gen #(.NCH(4), .NMI_CH(0), .NMI_HOLD(HOLD), .CEN_DIV(DIV_A), .VEC_BASE(VBASE)) u_a (
    .clk_sys(clk), .reset_n(rst_n), .src(a_src), .irq_en(a_en), .cpu_m1(a_m1), .cpu_io(a_io),
    .cen(a_cen), .nmi_n(a_nmi_n), .int_n(a_int_n), .vec(a_vec), .pend(a_pend)
  );

  cpu_irq_gen #(.NCH(2), .NMI_CH(0), .NMI_HOLD(HOLD), .CEN_DIV(1), .VEC_BASE(VBASE)) u_b (
    .clk_sys(clk), .reset_n(rst_n), .src(b_src), .irq_en(b_en), .cpu_m1(b_m1), .cpu_io(b_io),
    .cen(b_cen), .nmi_n(b_nmi_n), .int_n(b_int_n), .vec(b_vec), .pend(b_pend)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] ev(input logic [7:0] v);
    return VEC_ON ? v : 8'hFF;
  endfunction

  // Reference model for instance A: edges since reset, edge of last NMI trigger,
  // a per-source pending flag array and the last vector handed out.
  int m_edges;
  int m_last_trig;
  int m_vec;
  bit m_pend[4];
  bit [3:0] m_prev_src;
  bit m_prev_ack;

  task automatic model_reset();
    m_edges = 0;
    m_last_trig = -1;
    m_vec = VBASE;
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    m_prev_src = '0;
    m_prev_ack = 1'b0;
  endtask

  task automatic model_step();
    bit ack_now;
    int k;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_edges++;
    ack_now = a_m1 & a_io;
    if (ack_now && !m_prev_ack) begin
      k = -1;
      for (int i = 0; i < 4; i++) if (m_pend[i] && k < 0) k = i;
      if (k >= 0) begin
        m_pend[k] = 1'b0;
        m_vec = (VBASE + 2 * k) % 256;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (a_src[i] && !m_prev_src[i] && a_en[i]) begin
        if (i == 0) m_last_trig = m_edges;
        else m_pend[i] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) if (!a_en[i]) m_pend[i] = 1'b0;
    m_prev_src = a_src;
    m_prev_ack = ack_now;
  endtask

  task automatic check_a();
    logic [3:0] ep;
    bit nmi_low;
    for (int i = 0; i < 4; i++) ep[i] = m_pend[i];
    nmi_low = (m_last_trig >= 0) && ((m_edges - m_last_trig) < HOLD);
    chk("a_nmi_n", a_nmi_n, !nmi_low);
    chk("a_int_n", a_int_n, ep == 4'b0000);
    chk("a_pend", a_pend, ep);
    chk("a_vec", a_vec, ev(m_vec[7:0]));
    chk("a_cen", a_cen, (m_edges % DIV_A) == DIV_A - 1);
  endtask

  // Every clock edge of the run goes through here so the model never misses one.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_a();
  endtask

  typedef struct {
    logic [3:0] src;
    logic [3:0] en;
    logic       ack;
    logic [3:0] pend;
    logic       int_n;
    logic       nmi_n;
    logic [7:0] vec;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hE0};
    tbl[1]  = '{4'b1010, 4'b1111, 1'b0, 4'b1010, 1'b0, 1'b1, 8'hE0};
    tbl[2]  = '{4'b1010, 4'b1111, 1'b1, 4'b1000, 1'b0, 1'b1, 8'hE2};
    tbl[3]  = '{4'b1010, 4'b1111, 1'b1, 4'b1000, 1'b0, 1'b1, 8'hE2};
    tbl[4]  = '{4'b1010, 4'b1111, 1'b0, 4'b1000, 1'b0, 1'b1, 8'hE2};
    tbl[5]  = '{4'b1010, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b1, 8'hE6};
    tbl[6]  = '{4'b1010, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hE6};
    tbl[7]  = '{4'b1010, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b1, 8'hE6};
    tbl[8]  = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hE6};
    tbl[9]  = '{4'b0100, 4'b1011, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hE6};
    tbl[10] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hE6};
    tbl[11] = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b0, 1'b1, 8'hE6};
    tbl[12] = '{4'b0100, 4'b1011, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hE6};
    tbl[13] = '{4'b0001, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0, 8'hE6};
    tbl[14] = '{4'b0011, 4'b1111, 1'b0, 4'b0010, 1'b0, 1'b0, 8'hE6};
    tbl[15] = '{4'b0001, 4'b1111, 1'b0, 4'b0010, 1'b0, 1'b0, 8'hE6};
    tbl[16] = '{4'b0011, 4'b1111, 1'b1, 4'b0010, 1'b0, 1'b0, 8'hE2};
    tbl[17] = '{4'b0011, 4'b1111, 1'b0, 4'b0010, 1'b0, 1'b1, 8'hE2};
    tbl[18] = '{4'b0011, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b1, 8'hE2};
    tbl[19] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hE2};

    rst_n = 1'b0;
    a_src = '0; a_en = 4'b1111; a_m1 = 1'b0; a_io = 1'b0;
    b_src = '0; b_en = 2'b11;   b_m1 = 1'b0; b_io = 1'b0;
    model_reset();
    #2;
    chk("rst_a_cen", a_cen, 1'b0);
    chk("rst_a_nmi_n", a_nmi_n, 1'b1);
    chk("rst_a_int_n", a_int_n, 1'b1);
    chk("rst_a_pend", a_pend, 4'b0000);
    chk("rst_a_vec", a_vec, ev(VBASE));
    chk("rst_b_cen", b_cen, 1'b1);
    chk("rst_b_nmi_n", b_nmi_n, 1'b1);
    chk("rst_b_int_n", b_int_n, 1'b1);
    chk("rst_b_vec", b_vec, ev(VBASE));
    tick();
    tick();
    #3 rst_n = 1'b1;

    // Table vectors on instance A, starting straight out of reset.
    for (int r = 0; r < 20; r++) begin
      a_src = tbl[r].src;
      a_en  = tbl[r].en;
      a_m1  = tbl[r].ack;
      a_io  = tbl[r].ack;
      tick();
      chk($sformatf("tbl%0d_pend", r), a_pend, tbl[r].pend);
      chk($sformatf("tbl%0d_int_n", r), a_int_n, tbl[r].int_n);
      chk($sformatf("tbl%0d_nmi_n", r), a_nmi_n, tbl[r].nmi_n);
      chk($sformatf("tbl%0d_vec", r), a_vec, ev(tbl[r].vec));
    end
    a_src = '0; a_m1 = 1'b0; a_io = 1'b0;

    // Instance B: single NMI pulse lasts exactly HOLD cycles.
    tick();
    b_src = 2'b01;
    tick();
    chk("b_nmi_first", b_nmi_n, 1'b0);
    chk("b_cen", b_cen, 1'b1);
    for (int i = 1; i < HOLD; i++) begin
      tick();
      chk("b_nmi_hold", b_nmi_n, 1'b0);
    end
    tick();
    chk("b_nmi_release", b_nmi_n, 1'b1);

    // Retrigger three cycles in extends the pulse to HOLD after the retrigger.
    b_src = 2'b00;
    tick();
    b_src = 2'b01;
    tick();
    chk("b_rt_t0", b_nmi_n, 1'b0);
    tick();
    chk("b_rt_t1", b_nmi_n, 1'b0);
    b_src = 2'b00;
    tick();
    chk("b_rt_t2", b_nmi_n, 1'b0);
    b_src = 2'b01;
    tick();
    chk("b_rt_t3", b_nmi_n, 1'b0);
    for (int i = 0; i < HOLD - 1; i++) begin
      tick();
      chk("b_rt_ext", b_nmi_n, 1'b0);
    end
    tick();
    chk("b_rt_release", b_nmi_n, 1'b1);

    // INT on source 1, ack held for three cycles acts only once.
    b_src = 2'b10;
    tick();
    chk("b_int_set", b_int_n, 1'b0);
    chk("b_pend_set", b_pend, 2'b10);
    b_m1 = 1'b1;
    tick();
    chk("b_m1_only_pend", b_pend, 2'b10);
    b_io = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_ack_pend", b_pend, 2'b00);
      chk("b_ack_int_n", b_int_n, 1'b1);
      chk("b_ack_vec", b_vec, ev(8'hE2));
    end
    b_m1 = 1'b0; b_io = 1'b0; b_src = 2'b00;
    tick();

    // Randomized traffic on instance A: busy phase then a sparse phase.
    for (int n = 0; n < 700; n++) begin
      if (n < 350 || $urandom_range(0, 7) == 0) a_src = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) a_en[i] = ($urandom_range(0, 9) != 0);
      a_m1 = ($urandom_range(0, 3) != 0);
      a_io = ($urandom_range(0, 2) == 0);
      tick();
    end
    a_src = '0; a_en = 4'b1111; a_m1 = 1'b0; a_io = 1'b0;
    tick();

    // Asynchronous reset while NMI is low and an INT is pending.
    b_src = 2'b01;
    a_src = 4'b0011;
    tick();
    chk("pre_rst_b_nmi", b_nmi_n, 1'b0);
    chk("pre_rst_a_nmi", a_nmi_n, 1'b0);
    chk("pre_rst_a_pend", a_pend, 4'b0010);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_a_nmi_n", a_nmi_n, 1'b1);
    chk("midrst_a_int_n", a_int_n, 1'b1);
    chk("midrst_a_pend", a_pend, 4'b0000);
    chk("midrst_a_cen", a_cen, 1'b0);
    chk("midrst_a_vec", a_vec, ev(VBASE));
    chk("midrst_b_nmi_n", b_nmi_n, 1'b1);
    a_src = '0; b_src = '0;
    tick();
    tick();
    #3 rst_n = 1'b1;
    // Counters restart from zero: cen first after edge 16 and 33, no stale NMI.
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("post_rst_b_nmi", b_nmi_n, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
